// File: rtl/instr_prefetch_buf.sv
// instr_prefetch_buf: dual-port ROM instruction prefetcher feeding a circular buffer
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   redirect_valid/pc   flush the buffer and restart fetch at redirect_pc
//   ROM_A1/ROM_A2       ROM read addresses (fpc, fpc+1)
//   ROM_RD1/ROM_RD2     combinational ROM data for ROM_A1/ROM_A2
//   instr_valid/ready   head handshake to the consumer
//   instr_data/pc       head instruction word and its word address
//   count               occupied buffer entries
module instr_prefetch_buf #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [ADDR_W-1:0]          ROM_A1,
  output logic [ADDR_W-1:0]          ROM_A2,
  input  logic [DATA_W-1:0]          ROM_RD1,
  input  logic [DATA_W-1:0]          ROM_RD2,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DATA_W-1:0]          instr_data,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] r_fpc;
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_d  [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc [DEPTH];
  logic [CW-1:0]     w_free;
  logic [1:0]        w_n;
  logic              w_pop;
  logic [PW-1:0]     w_wp1;
  // free space counts only registered occupancy, so a same-cycle pop never frees a slot
  always_comb begin
    w_free = CW'(DEPTH) - r_count;
    w_n    = redirect_valid ? 2'd0 : (w_free >= CW'(2)) ? 2'd2 : (w_free == CW'(1)) ? 2'd1 : 2'd0;
    w_pop  = (r_count != '0) && instr_ready && !redirect_valid;
    w_wp1  = r_wp + PW'(1);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fpc   <= ADDR_W'(RESET_PC);
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_fpc   <= redirect_pc;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_fpc   <= r_fpc + ADDR_W'(w_n);
      r_wp    <= r_wp + PW'(w_n);
      r_rp    <= r_rp + PW'(w_pop);
      r_count <= r_count + CW'(w_n) - CW'(w_pop);
    end
  end
  // storage needs no reset: contents are masked whenever count is zero
  always_ff @(posedge CLK) begin
    if (w_n != 2'd0) begin
      r_mem_d[r_wp]  <= ROM_RD1;
      r_mem_pc[r_wp] <= r_fpc;
    end
    if (w_n == 2'd2) begin
      r_mem_d[w_wp1]  <= ROM_RD2;
      r_mem_pc[w_wp1] <= ROM_A2;
    end
  end
  always_comb begin
    ROM_A1      = r_fpc;
    ROM_A2      = r_fpc + ADDR_W'(1);
    instr_valid = r_count != '0;
    instr_data  = instr_valid ? r_mem_d[r_rp] : '0;
    instr_pc    = instr_valid ? r_mem_pc[r_rp] : '0;
    count       = r_count;
  end
endmodule

// File: tb/tb_instr_prefetch_buf.sv
// tb_instr_prefetch_buf: scoreboard bench for instr_prefetch_buf with ROM word[i] = i + 0x100
module tb_instr_prefetch_buf;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic [5:0]  ROM_A1, ROM_A2;
  logic [31:0] ROM_RD1, ROM_RD2;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [5:0]  instr_pc;
  logic [3:0]  count;
  int checks = 0;
  int failures = 0;
  logic [5:0] q[$];
  logic [5:0] m_fpc = 6'd0;
  int m_cnt = 0;

  instr_prefetch_buf #(.ADDR_W(6), .DATA_W(32), .DEPTH(8), .RESET_PC(0)) dut (
    .CLK(CLK), .RST(RST), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ROM_A1(ROM_A1), .ROM_A2(ROM_A2), .ROM_RD1(ROM_RD1), .ROM_RD2(ROM_RD2),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .count(count)
  );

  always #5 CLK = ~CLK;
  assign ROM_RD1 = 32'(ROM_A1) + 32'h100;
  assign ROM_RD2 = 32'(ROM_A2) + 32'h100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [5:0] pc);
    q.delete();
    m_cnt = 0;
    m_fpc = pc;
  endtask

  task automatic cyc();
    int n;
    bit pop;
    @(posedge CLK);
    if (redirect_valid) model_reset(redirect_pc);
    else begin
      pop = (m_cnt != 0) && instr_ready;
      n = (8 - m_cnt >= 2) ? 2 : 8 - m_cnt;
      for (int k = 0; k < n; k++) begin
        q.push_back(m_fpc);
        m_fpc = m_fpc + 6'd1;
      end
      if (pop) void'(q.pop_front());
      m_cnt = m_cnt + n - (pop ? 1 : 0);
    end
    #1;
    check("count", 64'(count), 64'(m_cnt));
    check("valid", 64'(instr_valid), 64'(m_cnt != 0));
    check("rom_a1", 64'(ROM_A1), 64'(m_fpc));
    check("rom_a2", 64'(ROM_A2), 64'(6'(m_fpc + 6'd1)));
    if (q.size() != 0) begin
      check("head_pc", 64'(instr_pc), 64'(q[0]));
      check("head_data", 64'(instr_data), 64'(32'(q[0]) + 32'h100));
    end else begin
      check("idle_pc", 64'(instr_pc), 64'd0);
      check("idle_data", 64'(instr_data), 64'd0);
    end
  endtask

  task automatic redirect(input logic [5:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_a1", 64'(ROM_A1), 64'd0);
    check("rst_a2", 64'(ROM_A2), 64'd1);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    redirect(6'd0);
    check("redir_cnt0", 64'(count), 64'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("fill_count", 64'(count), 64'd8);
    check("fill_a1", 64'(ROM_A1), 64'd8);
    redirect(6'd1);
    for (int i = 0; i < 3; i++) cyc();
    instr_ready = 1'b1;
    cyc();
    check("odd_count", 64'(count), 64'd7);
    instr_ready = 1'b0;
    cyc();
    check("single_count", 64'(count), 64'd8);
    check("single_a1", 64'(ROM_A1), 64'd10);
    instr_ready = 1'b1;
    cyc();
    redirect(6'h2A);
    check("redir_valid", 64'(instr_valid), 64'd0);
    check("redir_a1", 64'(ROM_A1), 64'h2A);
    cyc();
    check("redir_head", 64'(instr_pc), 64'h2A);
    instr_ready = 1'b0;
    redirect(6'h3F);
    check("wrap_a2", 64'(ROM_A2), 64'd0);
    cyc();
    check("wrap_head", 64'(instr_pc), 64'h3F);
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    #1 RST = 1'b1;
    #1;
    check("arst_valid", 64'(instr_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_data", 64'(instr_data), 64'd0);
    check("arst_a1", 64'(ROM_A1), 64'd0);
    #2 RST = 1'b0;
    model_reset(6'd0);
    for (int i = 0; i < 10; i++) cyc();
    for (int i = 0; i < 300; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 6'($urandom);
      cyc();
    end
    redirect_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buf.md
INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of PC and ROM ports.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 8, buffer entries; power of two, >= 4.
REQ-004 Parameter RESET_PC, default 0, word address fetched first after reset.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 redirect_valid  input  1  flush the buffer and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  ADDR_W  new fetch word address.
REQ-009 ROM_A1  output  ADDR_W  ROM read port 1 address.
REQ-010 ROM_A2  output  ADDR_W  ROM read port 2 address.
REQ-011 ROM_RD1  input  DATA_W  combinational ROM data for ROM_A1, same cycle.
REQ-012 ROM_RD2  input  DATA_W  combinational ROM data for ROM_A2, same cycle.
REQ-013 instr_valid  output  1  head entry present.
REQ-014 instr_ready  input  1  consumer accepts head this cycle.
REQ-015 instr_data  output  DATA_W  head instruction word.
REQ-016 instr_pc  output  ADDR_W  word address of head instruction.
REQ-017 count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-018 Fetch pointer fpc SHALL drive ROM_A1 = fpc, ROM_A2 = fpc+1 modulo 2^ADDR_W, combinationally from registered fpc.
REQ-019 free = DEPTH - count, from registered count only; a same-cycle pop SHALL NOT create extra free space.
REQ-020 With no redirect and free >= 2: push {ROM_RD1, fpc} then {ROM_RD2, fpc+1}, in order; fpc += 2.
REQ-021 With no redirect and free == 1: push {ROM_RD1, fpc} only; fpc += 1.
REQ-022 With free == 0: no push; fpc holds.
REQ-023 fpc and pc arithmetic SHALL wrap modulo 2^ADDR_W; at fpc = 2^ADDR_W-1 port 2 reads address 0.
REQ-024 instr_valid = (count != 0); instr_data/instr_pc = head entry when valid, else all zeros.
REQ-025 Pop occurs when instr_valid && instr_ready; the head advances one entry at the next edge.
REQ-026 count_next = count + pushes - pop; simultaneous push and pop SHALL both take effect.
REQ-027 redirect_valid high: at the edge count := 0, read/write pointers := 0, fpc := redirect_pc; push and pop suppressed that cycle.
REQ-028 An instruction is delivered to the consumer exactly once, in increasing pc order, between redirects.
REQ-029 Latency: the first instruction after reset or redirect is valid the cycle after fpc takes its new value.
REQ-030 Storage SHALL be a DEPTH-entry circular buffer with pointers wrapping modulo DEPTH.

Reset
REQ-031 While RST is high: count = 0, instr_valid = 0, instr_data = 0, instr_pc = 0, pointers = 0, fpc = RESET_PC (ROM_A1 = RESET_PC, ROM_A2 = RESET_PC+1).
REQ-032 Reset asserted mid-fetch or mid-pop SHALL discard all entries immediately, without waiting for a clock edge.
REQ-033 The first push occurs at the first rising edge after RST deasserts.

Verification
REQ-034 Reset release, instr_ready=1, ROM word[i]=i+0x100 -> pcs 0,1,2,... with data 0x100,0x101,... consecutively, no gaps after fill, count stays <= 8.
REQ-035 instr_ready=0 for 10 cycles -> count rises 2,4,6,8 and holds at 8; fpc = 8; ROM_A1 = 8.
REQ-036 Buffer count 7, no pop -> single push of pc 7, count 8, fpc 8.
REQ-037 Redirect to pc 0x2A with count 5 -> next cycle count 0, instr_valid 0, ROM_A1 = 0x2A; following cycle head pc 0x2A.
REQ-038 fpc = 0x3F (ADDR_W=6) -> ROM_A2 = 0x00; pushed pcs 0x3F then 0x00.
REQ-039 RST pulse mid-stream for 3 ns between edges -> instr_valid 0 immediately; fetch restarts at RESET_PC.
